sync_req_arbiter: RTL and testbench
===================================

Name: sync_req_arbiter

Overview:
- Accepts N asynchronous request lines from foreign clock domains, for example the sound DMA side and the keyboard/mouse serial side.
- Synchronises each line with a resettable 2-FF stage and turns each rising edge into a pending event.
- Grants a single shared service port to one requester at a time in round-robin order, with a grant/accept/done handshake and a busy watchdog.
- Sits between the raw CDC synchronisers and the shared single-port service logic: monitor-bus transmitter and register file.

Parameters:
- N, 4: number of requesters (2..8).
- IDW, 2: width of grant_id; must equal ceil(log2(N)).
- TIMEOUT, 255: maximum cycles spent in BUSY waiting for done. 0 disables the watchdog.
- TW, 8: width of the watchdog counter; TIMEOUT must be ≤ 2^TW−1.

Ports:
- clk, in, 1: single system clock; all state updates on posedge.
- rst_n, in, 1: asynchronous active-low reset.
- req_async, in, N: asynchronous request lines; a rising edge is one request.
- grant_valid, out, 1: a grant is being offered.
- grant_id, out, IDW: index of the requester being offered the grant.
- grant_ready, in, 1: the service accepts the offered grant.
- done, in, 1: single-cycle pulse; the service has finished the current request.
- busy, out, 1: high from acceptance until done or timeout.
- pending, out, N: per-requester pending flags.
- overrun, out, N: sticky; a new edge arrived while pending was already set.
- clr_overrun, in, 1: clears all overrun bits.
- timeout, out, 1: single-cycle pulse when the watchdog expires.

Behaviour:
- Reset: all flops clear asynchronously on rst_n low, including synchroniser stages and edge registers. Outputs after reset: grant_valid=0, grant_id=0, busy=0, pending=0, overrun=0, timeout=0; state=IDLE; last_id=N−1, so the first search starts at 0.
- Synchroniser and edge detect:
  - Per bit: s1 <= req_async, then s2 <= s1, then prev <= s2.
  - edge[i] = s2 & ~prev.
  - A request already high when reset is released produces exactly one edge.
- Latency: req_async rises with setup before edge k → s2=1 after k+1 → pending[i]=1 after k+2.
- Pending update, per bit, priority high to low:
  1. edge[i] sets pending[i]. If pending[i] was already 1 and this is not the clear cycle, overrun[i] is set as well.
  2. Acceptance of grant i clears pending[i].
  - Edge and acceptance in the same cycle: pending stays 1, no overrun (the new event is queued).
- Overrun: clr_overrun clears all bits. A simultaneous set for a bit wins over the clear for that bit.
- FSM state IDLE:
  - If any pending bit is set, select the first set bit searching last_id+1, last_id+2, … modulo N.
  - Register the selection into grant_id, drive grant_valid=1, move to GRANT.
  - grant_valid is therefore asserted one cycle after pending becomes visible.
- FSM state GRANT:
  - grant_id is held stable; grant_valid stays 1 until grant_ready is sampled high.
  - Pending bits newly set in GRANT do not change grant_id (no re-arbitration).
  - On grant_ready: pending[grant_id] cleared, last_id <= grant_id, grant_valid <= 0, busy <= 1, watchdog counter <= 0, move to BUSY.
  - done is ignored in GRANT.
- FSM state BUSY:
  - The counter increments each cycle and saturates.
  - On done: busy <= 0, move to IDLE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT−1 with no done: timeout pulses for 1 cycle, busy <= 0, move to IDLE.
  - done and expiry in the same cycle: done wins, no timeout pulse.
  - grant_ready is ignored in BUSY.
- Back-to-back: from BUSY→IDLE, the next grant_valid appears 1 cycle later. No zero-cycle turnaround.
- rst_n low mid-transaction: immediate return to the reset values above. All pending events are discarded.

Decomposition:
- Shared package/include `nextasic_defs`:
  - FSM state encodings: ST_IDLE=2'd0, ST_GRANT=2'd1, ST_BUSY=2'd2.
  - Default N/TIMEOUT constants.
- Sub-module `sync2_rst`: resettable 2-FF synchroniser (in, clk, rst_n → out), instantiated N times via generate.
- Round-robin pick is a combinational function inside sync_req_arbiter.

Test Plan:
- Reset release with req_async=4'b0100 held → pending=4'b0100 on the 3rd clk; grant_valid=1, grant_id=2 on the 4th; busy=0.
- Edges on req 0, 1 and 3 together, grant_ready tied 1, done 2 cycles after each busy → grant order 0, 1, 3. Then a new edge on 0 → the next grant is 0 (wrap after 3).
- Second edge on req 1 while pending[1]=1 → overrun=4'b0010. clr_overrun pulse → 0. Clear coincident with a new overrun edge → bit stays 1.
- Edge on req 2 arriving in the same cycle as acceptance of grant 2 → pending[2] stays 1, overrun[2]=0, grant 2 re-offered after done.
- TIMEOUT=5, no done → timeout pulses 5 cycles after the acceptance edge, busy falls, state IDLE. Variant with done in that same cycle → no timeout pulse.
- rst_n pulsed low during BUSY → busy, grant_valid, pending and overrun all 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/sync_req_arbiter_pkg.sv
// Shared definitions for the request arbiter: FSM encodings and default sizing.
package nextasic_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_TW      = 8;

endpackage

// File: rtl/sync_req_arbiter_sync2_rst.sv
// Resettable two-flop synchroniser for one asynchronous request line.
module sync2_rst (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for asynchronous request lines sharing one service port,
// with grant/accept/done handshake and a busy watchdog.
module sync_req_arbiter
    import nextasic_defs::*;
#(
    parameter int N       = DEF_N,
    parameter int IDW     = 2,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = DEF_TW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_async,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    input  logic           grant_ready,
    input  logic           done,
    output logic           busy,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overrun,
    input  logic           clr_overrun,
    output logic           timeout
);

    localparam logic [TW-1:0] EXP_AT = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    // First set bit strictly after 'last', wrapping modulo N.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                               input logic [IDW-1:0] last);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    logic [N-1:0]   s2, prev, rise;
    state_t         state, state_d;
    logic [IDW-1:0] last_id, last_d, gid_d;
    logic [TW-1:0]  cnt, cnt_d;
    logic           gv_d, busy_d, to_d;
    logic           accept, expire;
    logic [N-1:0]   acc_mask, pending_d, overrun_d;

    for (genvar i = 0; i < N; i++) begin : g_sync
        sync2_rst u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_async[i]),
            .q     (s2[i])
        );
    end

    assign rise   = s2 & ~prev;
    assign accept = (state == ST_GRANT) && grant_ready;
    assign expire = (TIMEOUT != 0) && (cnt == EXP_AT);

    always_comb begin
        acc_mask = '0;
        if (accept) acc_mask[grant_id] = 1'b1;
    end

    // An edge landing on the acceptance cycle re-queues the request, not an overrun.
    assign pending_d = (pending & ~acc_mask) | rise;
    assign overrun_d = (overrun & ~{N{clr_overrun}}) | (rise & pending & ~acc_mask);

    always_comb begin
        state_d = state;
        gv_d    = grant_valid;
        gid_d   = grant_id;
        busy_d  = busy;
        last_d  = last_id;
        cnt_d   = cnt;
        to_d    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|pending) begin
                    gid_d   = rr_pick(pending, last_id);
                    gv_d    = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_ready) begin
                    last_d  = grant_id;
                    gv_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = (&cnt) ? cnt : cnt + 1'b1;
                if (done) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (expire) begin
                    to_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gv_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prev        <= '0;
            pending     <= '0;
            overrun     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
            last_id     <= IDW'(N - 1);
            cnt         <= '0;
        end else begin
            state       <= state_d;
            prev        <= s2;
            pending     <= pending_d;
            overrun     <= overrun_d;
            grant_valid <= gv_d;
            grant_id    <= gid_d;
            busy        <= busy_d;
            timeout     <= to_d;
            last_id     <= last_d;
            cnt         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Bench for sync_req_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a request-level behavioural model.
module tb_sync_req_arbiter;

    localparam int N  = 4;
    localparam int TO = 5;

    logic       clk, rst_n;
    logic [3:0] req_async, pending, overrun;
    logic       grant_valid, grant_ready, done, busy, clr_overrun, timeout;
    logic [1:0] grant_id;

    sync_req_arbiter #(.N(N), .IDW(2), .TIMEOUT(TO), .TW(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_async   (req_async),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_ready (grant_ready),
        .done        (done),
        .busy        (busy),
        .pending     (pending),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: raw request samples of the last three clocks and the
    // externally visible view of the arbiter.
    typedef struct packed {
        bit [3:0] h1, h2, h3;
        bit [3:0] pend, ov;
        bit       gv, busy, to;
        bit [1:0] gid, last;
        bit [7:0] age;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mreset();
        mdl_t r;
        r      = '0;
        r.last = 2'd3;
        return r;
    endfunction

    function automatic mdl_t model_next(input mdl_t s, input bit [3:0] req,
                                        input bit gr, input bit d, input bit clr);
        mdl_t     n;
        bit [3:0] e, accm;
        int       idx;
        bit       found;
        n    = s;
        n.to = 1'b0;
        // A request counts once its line, seen two clocks ago, was low three clocks ago.
        e    = s.h2 & ~s.h3;
        n.h3 = s.h2;
        n.h2 = s.h1;
        n.h1 = req;
        accm = (s.gv && gr) ? (4'b0001 << s.gid) : 4'b0000;
        n.pend = (s.pend & ~accm) | e;
        n.ov   = (clr ? 4'b0000 : s.ov) | (e & s.pend & ~accm);
        if (s.busy) begin
            if (d) n.busy = 1'b0;
            else if (TO != 0 && int'(s.age) + 1 == TO) begin
                n.busy = 1'b0;
                n.to   = 1'b1;
            end else n.age = s.age + 8'd1;
        end else if (s.gv) begin
            if (gr) begin
                n.gv   = 1'b0;
                n.busy = 1'b1;
                n.last = s.gid;
                n.age  = 8'd0;
            end
        end else if (s.pend != 4'b0000) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                idx = (int'(s.last) + k) % N;
                if (!found && s.pend[idx]) begin
                    n.gid = 2'(idx);
                    found = 1'b1;
                end
            end
            n.gv = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= mreset();
        else        m <= model_next(m, req_async, grant_ready, done, clr_overrun);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_grant_valid", int'(grant_valid), int'(m.gv));
            chk("m_grant_id",    int'(grant_id),    int'(m.gid));
            chk("m_busy",        int'(busy),        int'(m.busy));
            chk("m_pending",     int'(pending),     int'(m.pend));
            chk("m_overrun",     int'(overrun),     int'(m.ov));
            chk("m_timeout",     int'(timeout),     int'(m.to));
        end
    end

    int glog[$];
    always @(posedge clk)
        if (rst_n && grant_valid && grant_ready) glog.push_back(int'(grant_id));

    // mode 0: handshake driven directly; 1: accept always, done after dly busy
    // cycles (0 = never); 2: random handshake.
    int mode = 0;
    int dly  = 2;
    int bcnt = 0;

    task automatic step();
        @(negedge clk);
        if (mode == 1) begin
            grant_ready = 1'b1;
            if (busy) begin
                bcnt++;
                done = (dly != 0) && (bcnt == dly);
            end else begin
                bcnt = 0;
                done = 1'b0;
            end
        end else if (mode == 2) begin
            grant_ready = ($urandom_range(1) == 1);
            done        = ($urandom_range(3) == 0);
        end
    endtask

    task automatic do_reset();
        mode        = 0;
        rst_n       = 1'b0;
        req_async   = '0;
        grant_ready = 1'b0;
        done        = 1'b0;
        clr_overrun = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_gv();
        int n = 0;
        while (!grant_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_grant_valid", int'(grant_valid), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_async = 4'b0100; grant_ready = 1'b0;
        done = 1'b0; clr_overrun = 1'b0;
        step(); step();
        chk("rst_grant_valid", int'(grant_valid), 0);
        chk("rst_grant_id",    int'(grant_id),    0);
        chk("rst_busy",        int'(busy),        0);
        chk("rst_pending",     int'(pending),     0);
        chk("rst_overrun",     int'(overrun),     0);
        chk("rst_timeout",     int'(timeout),     0);

        // Request already high at reset release.
        rst_n = 1'b1;
        step(); step(); step();
        chk("held_pending3", int'(pending), 4'b0100);
        chk("held_gv3",      int'(grant_valid), 0);
        step();
        chk("held_gv4",   int'(grant_valid), 1);
        chk("held_gid4",  int'(grant_id), 2);
        chk("held_busy4", int'(busy), 0);
        mode = 1; dly = 2;
        repeat (8) step();

        // Simultaneous edges on 0,1,3 then a later edge on 0.
        do_reset();
        glog.delete();
        mode = 1; dly = 2;
        req_async = 4'b1011;
        repeat (30) step();
        chk("order_count", glog.size(), 3);
        if (glog.size() >= 3) begin
            chk("order_0", glog[0], 0);
            chk("order_1", glog[1], 1);
            chk("order_2", glog[2], 3);
        end
        req_async = 4'b0000;
        repeat (3) step();
        req_async = 4'b0001;
        repeat (12) step();
        chk("wrap_count", glog.size(), 4);
        if (glog.size() >= 4) chk("wrap_id", glog[3], 0);

        // Overrun set, clear, and clear colliding with a new overrun.
        do_reset();
        req_async = 4'b0010;
        repeat (4) step();
        chk("ov_pending", int'(pending), 4'b0010);
        req_async = 4'b0000; step(); step();
        req_async = 4'b0010;
        repeat (4) step();
        chk("ov_set", int'(overrun), 4'b0010);
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("ov_clr", int'(overrun), 4'b0000);
        req_async = 4'b0000; step(); step();
        req_async = 4'b0010; step(); step();
        clr_overrun = 1'b1; step(); clr_overrun = 1'b0;
        chk("ov_clr_vs_set", int'(overrun), 4'b0010);

        // Edge on 2 coinciding with acceptance of grant 2.
        do_reset();
        req_async = 4'b0100; step();
        req_async = 4'b0000; step(); step();
        req_async = 4'b0100; step(); step();
        grant_ready = 1'b1; step();
        chk("requeue_pending", int'(pending), 4'b0100);
        chk("requeue_overrun", int'(overrun), 0);
        chk("requeue_busy",    int'(busy), 1);
        grant_ready = 1'b0; done = 1'b1; step(); done = 1'b0;
        chk("turnaround_gv",   int'(grant_valid), 0);
        step();
        chk("requeue_gv",  int'(grant_valid), 1);
        chk("requeue_gid", int'(grant_id), 2);

        // Watchdog expiry, then done racing the expiry cycle.
        do_reset();
        req_async = 4'b0001;
        wait_gv();
        grant_ready = 1'b1; step(); grant_ready = 1'b0;
        chk("wd_busy", int'(busy), 1);
        repeat (4) step();
        chk("wd_early_to",   int'(timeout), 0);
        chk("wd_early_busy", int'(busy), 1);
        step();
        chk("wd_pulse", int'(timeout), 1);
        chk("wd_busy_fall", int'(busy), 0);
        step();
        chk("wd_pulse_end", int'(timeout), 0);
        req_async = 4'b0000; step(); step();
        req_async = 4'b0001;
        wait_gv();
        grant_ready = 1'b1; step(); grant_ready = 1'b0;
        repeat (4) step();
        done = 1'b1; step(); done = 1'b0;
        chk("wd_done_wins_to",   int'(timeout), 0);
        chk("wd_done_wins_busy", int'(busy), 0);
        step();
        chk("wd_done_wins_to2", int'(timeout), 0);

        // Asynchronous reset while busy.
        do_reset();
        mode = 1; dly = 0;
        req_async = 4'b1111;
        begin
            int n = 0;
            while (!busy && n < 20) begin
                step();
                n++;
            end
        end
        chk("ar_reached_busy", int'(busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy",    int'(busy), 0);
        chk("ar_gv",      int'(grant_valid), 0);
        chk("ar_pending", int'(pending), 0);
        chk("ar_overrun", int'(overrun), 0);
        chk("ar_timeout", int'(timeout), 0);
        step();
        rst_n = 1'b1;
        repeat (10) step();

        // Random traffic against the model.
        do_reset();
        mode = 2;
        repeat (3000) begin
            step();
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) req_async[i] = ~req_async[i];
            clr_overrun = ($urandom_range(9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
